// File: rtl/rv64g_pkg.sv
// rtl/rv64g_pkg.sv - shared constants and entry type for the writeback sequencer
package rv64g_pkg;

  localparam int XLEN    = 64;
  localparam int NUM_REG = 64;
  localparam int RD_W    = $clog2(NUM_REG);

  // One in-flight instruction: allocated at launch, filled at completion
  typedef struct packed {
    logic            valid;
    logic            done;
    logic [RD_W-1:0] rd;
    logic [XLEN-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/rv64g_writeback_sequencer_if.sv
// rtl/rv64g_writeback_sequencer_if.sv - launch, completion, writeback and lock signals
interface rv64g_writeback_sequencer_if #(
  parameter int TAG_W   = 3,
  parameter int RD_W    = 6,
  parameter int XLEN    = 64,
  parameter int NUM_REG = 64
);

  logic               launch_valid_i;
  logic               launch_ready_o;
  logic [RD_W-1:0]    launch_rd_i;
  logic [TAG_W-1:0]   launch_tag_o;
  logic               cmpl_valid_i;
  logic [TAG_W-1:0]   cmpl_tag_i;
  logic [XLEN-1:0]    cmpl_data_i;
  logic               cmpl_err_o;
  logic               wb_valid_o;
  logic               wb_ready_i;
  logic [RD_W-1:0]    wb_rd_o;
  logic [XLEN-1:0]    wb_data_o;
  logic [NUM_REG-1:0] locks_o;

  // Sequencer side
  modport slave (
    input  launch_valid_i, launch_rd_i, cmpl_valid_i, cmpl_tag_i, cmpl_data_i, wb_ready_i,
    output launch_ready_o, launch_tag_o, cmpl_err_o, wb_valid_o, wb_rd_o, wb_data_o, locks_o
  );

  // Launcher / execution units / register file side
  modport master (
    output launch_valid_i, launch_rd_i, cmpl_valid_i, cmpl_tag_i, cmpl_data_i, wb_ready_i,
    input  launch_ready_o, launch_tag_o, cmpl_err_o, wb_valid_o, wb_rd_o, wb_data_o, locks_o
  );

endinterface

// File: rtl/rv64g_reg_lock_map.sv
// rtl/rv64g_reg_lock_map.sv - per-register lock bitmap from the in-flight entries
module rv64g_reg_lock_map
  import rv64g_pkg::*;
#(
  parameter int NUM_ENTRIES = 7
) (
  input  logic [NUM_ENTRIES-1:0] valid_i,
  input  logic [RD_W-1:0]        rd_i [NUM_ENTRIES],
  output logic [NUM_REG-1:0]     locks_o
);

  // OR together the one-hot decode of every valid entry's destination; x0 never locks
  always_comb begin
    locks_o = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (valid_i[i]) begin
        locks_o[rd_i[i]] = 1'b1;
      end
    end
    locks_o[0] = 1'b0;
  end

endmodule

// File: rtl/rv64g_writeback_sequencer.sv
// rtl/rv64g_writeback_sequencer.sv - in-order writeback of out-of-order results; option RV64G_WB_BYPASS_EN
module rv64g_writeback_sequencer
  import rv64g_pkg::*;
#(
  parameter int NUM_OUTSTANDING = 7
) (
  input logic                       clk_i,
  input logic                       arst_i,
  input logic                       flush_i,
  rv64g_writeback_sequencer_if.slave bus
);

  localparam int TAG_W = (NUM_OUTSTANDING > 1) ? $clog2(NUM_OUTSTANDING) : 1;
  localparam int CNT_W = $clog2(NUM_OUTSTANDING + 1);
  localparam logic [TAG_W-1:0] LAST_IDX = TAG_W'(NUM_OUTSTANDING - 1);
  localparam logic [TAG_W:0]   DEPTH    = (TAG_W + 1)'(NUM_OUTSTANDING);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(NUM_OUTSTANDING);

  wb_entry_t        ent_q [NUM_OUTSTANDING];
  logic [TAG_W-1:0] head_q, head_d;
  logic [TAG_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             cmpl_err_q, cmpl_err_d;

  wb_entry_t head_ent;
  logic      tag_in_range;
  logic      cmpl_ent_valid, cmpl_ent_done;
  logic      cmpl_ok, cmpl_store;
  logic      head_done, byp_hit;
  logic      wb_valid, wb_fire;
  logic      launch_ready, launch_fire;
  logic [XLEN-1:0] wb_data;

  logic [NUM_OUTSTANDING-1:0] ent_valid;
  logic [RD_W-1:0]            ent_rd [NUM_OUTSTANDING];

  // Circular pointer increment; depth need not be a power of two
  function automatic logic [TAG_W-1:0] ptr_inc(input logic [TAG_W-1:0] p);
    return (p == LAST_IDX) ? '0 : p + 1'b1;
  endfunction

  assign head_ent     = ent_q[head_q];
  assign tag_in_range = {1'b0, bus.cmpl_tag_i} < DEPTH;

  // Look up the entry addressed by the completing tag; out-of-range tags look free
  always_comb begin
    cmpl_ent_valid = 1'b0;
    cmpl_ent_done  = 1'b0;
    if (tag_in_range) begin
      cmpl_ent_valid = ent_q[bus.cmpl_tag_i].valid;
      cmpl_ent_done  = ent_q[bus.cmpl_tag_i].done;
    end
  end

  assign cmpl_ok   = bus.cmpl_valid_i & tag_in_range & cmpl_ent_valid & ~cmpl_ent_done;
  assign head_done = head_ent.valid & head_ent.done;

  // Head selection: stored result, or (bypass build) the result arriving for the head this cycle
  always_comb begin
`ifdef RV64G_WB_BYPASS_EN
    byp_hit  = cmpl_ok & (bus.cmpl_tag_i == head_q);
    wb_valid = head_done | byp_hit;
    wb_data  = head_done ? head_ent.data : bus.cmpl_data_i;
`else
    byp_hit  = 1'b0;
    wb_valid = head_done;
    wb_data  = head_ent.data;
`endif
  end

  assign launch_ready = count_q < FULL_CNT;
  assign launch_fire  = bus.launch_valid_i & launch_ready;
  assign wb_fire      = wb_valid & bus.wb_ready_i;
  // A bypassed result that retires immediately is never written into the buffer
  assign cmpl_store   = cmpl_ok & ~(byp_hit & bus.wb_ready_i);

  // Next-state for pointers, occupancy and the error pulse
  always_comb begin
    head_d     = wb_fire ? ptr_inc(head_q) : head_q;
    tail_d     = launch_fire ? ptr_inc(tail_q) : tail_q;
    count_d    = count_q;
    if (launch_fire && !wb_fire) begin
      count_d = count_q + 1'b1;
    end else if (!launch_fire && wb_fire) begin
      count_d = count_q - 1'b1;
    end
    cmpl_err_d = bus.cmpl_valid_i & ~cmpl_ok;
  end

  // Entry array and pointer registers; flush wins over every other update
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      for (int i = 0; i < NUM_OUTSTANDING; i++) ent_q[i] <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      cmpl_err_q <= 1'b0;
    end else if (flush_i) begin
      for (int i = 0; i < NUM_OUTSTANDING; i++) ent_q[i] <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      cmpl_err_q <= 1'b0;
    end else begin
      if (launch_fire) begin
        ent_q[tail_q].valid <= 1'b1;
        ent_q[tail_q].done  <= 1'b0;
        ent_q[tail_q].rd    <= bus.launch_rd_i;
        ent_q[tail_q].data  <= '0;
      end
      if (cmpl_store) begin
        ent_q[bus.cmpl_tag_i].done <= 1'b1;
        ent_q[bus.cmpl_tag_i].data <= bus.cmpl_data_i;
      end
      if (wb_fire) begin
        ent_q[head_q].valid <= 1'b0;
        ent_q[head_q].done  <= 1'b0;
      end
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      cmpl_err_q <= cmpl_err_d;
    end
  end

  // Flatten entry state for the lock decoder
  always_comb begin
    for (int i = 0; i < NUM_OUTSTANDING; i++) begin
      ent_valid[i] = ent_q[i].valid;
      ent_rd[i]    = ent_q[i].rd;
    end
  end

  rv64g_reg_lock_map #(
    .NUM_ENTRIES(NUM_OUTSTANDING)
  ) u_lock_map (
    .valid_i (ent_valid),
    .rd_i    (ent_rd),
    .locks_o (bus.locks_o)
  );

  assign bus.launch_ready_o = launch_ready;
  assign bus.launch_tag_o   = tail_q;
  assign bus.cmpl_err_o     = cmpl_err_q;
  assign bus.wb_valid_o     = wb_valid;
  assign bus.wb_rd_o        = head_ent.rd;
  assign bus.wb_data_o      = wb_data;

endmodule

// File: tb/tb_rv64g_writeback_sequencer.sv
// tb/tb_rv64g_writeback_sequencer.sv - self-checking bench for rv64g_writeback_sequencer
module tb_rv64g_writeback_sequencer;

  logic clk = 1'b0;
  logic arst = 1'b1;
  logic flush = 1'b0;

  always #5 clk = ~clk;

  rv64g_writeback_sequencer_if #(.TAG_W(3), .RD_W(6), .XLEN(64), .NUM_REG(64)) bus ();

  rv64g_writeback_sequencer #(.NUM_OUTSTANDING(7)) dut (
    .clk_i   (clk),
    .arst_i  (arst),
    .flush_i (flush),
    .bus     (bus)
  );

  int n_vec = 0;
  int n_bad = 0;
  bit model_on = 1'b0;

  typedef struct {
    int          tag;
    int          rd;
    bit          done;
    logic [63:0] data;
  } rec_t;

  rec_t q[$];
  int   nxt_tag = 0;
  bit   err_pend = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Launch-ordered queue model, checked and advanced on every falling edge
  always @(negedge clk) begin : compare
    logic [63:0] lk;
    logic [63:0] ed;
    bit          ev;
    bit          rdy;
    int          er;
    int          idx;
    rec_t        r;
    if (arst) begin
      q.delete();
      nxt_tag  = 0;
      err_pend = 1'b0;
    end else if (model_on) begin
      rdy = q.size() < 7;
      lk = '0;
      foreach (q[i]) lk[q[i].rd] = 1'b1;
      lk[0] = 1'b0;
      ev = 1'b0; er = 0; ed = '0;
      if (q.size() > 0 && q[0].done) begin
        ev = 1'b1; er = q[0].rd; ed = q[0].data;
      end
`ifdef RV64G_WB_BYPASS_EN
      else if (q.size() > 0 && bus.cmpl_valid_i && int'(bus.cmpl_tag_i) == q[0].tag) begin
        ev = 1'b1; er = q[0].rd; ed = bus.cmpl_data_i;
      end
`endif
      chk("launch_ready", bus.launch_ready_o, rdy);
      chk("launch_tag", bus.launch_tag_o, nxt_tag);
      chk("locks", bus.locks_o, lk);
      chk("cmpl_err", bus.cmpl_err_o, err_pend);
      chk("wb_valid", bus.wb_valid_o, ev);
      if (ev && bus.wb_valid_o) begin
        chk("wb_rd", bus.wb_rd_o, er);
        chk("wb_data", bus.wb_data_o, ed);
      end
      if (flush) begin
        q.delete();
        nxt_tag  = 0;
        err_pend = 1'b0;
      end else begin
        idx = -1;
        foreach (q[i]) if (q[i].tag == int'(bus.cmpl_tag_i)) idx = i;
        err_pend = 1'b0;
        if (bus.cmpl_valid_i) begin
          if (idx >= 0 && !q[idx].done) begin
            q[idx].done = 1'b1;
            q[idx].data = bus.cmpl_data_i;
          end else begin
            err_pend = 1'b1;
          end
        end
        if (ev && bus.wb_ready_i) void'(q.pop_front());
        if (bus.launch_valid_i && rdy) begin
          r.tag = nxt_tag; r.rd = int'(bus.launch_rd_i); r.done = 1'b0; r.data = '0;
          q.push_back(r);
          nxt_tag = (nxt_tag + 1) % 7;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    bus.launch_valid_i = 1'b0;
    bus.cmpl_valid_i   = 1'b0;
    flush              = 1'b0;
  endtask

  task automatic launch(input int rd);
    bus.launch_valid_i = 1'b1;
    bus.launch_rd_i    = 6'(rd);
    tick();
  endtask

  task automatic complete(input int tag, input logic [63:0] d);
    bus.cmpl_valid_i = 1'b1;
    bus.cmpl_tag_i   = 3'(tag);
    bus.cmpl_data_i  = d;
    tick();
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.launch_valid_i = 1'b0;
    bus.launch_rd_i    = '0;
    bus.cmpl_valid_i   = 1'b0;
    bus.cmpl_tag_i     = '0;
    bus.cmpl_data_i    = '0;
    bus.wb_ready_i     = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", bus.launch_ready_o, 1);
    chk("rst_wb_valid", bus.wb_valid_o, 0);
    chk("rst_err", bus.cmpl_err_o, 0);
    chk("rst_locks", bus.locks_o, 0);
    chk("rst_tag", bus.launch_tag_o, 0);
    arst = 1'b0;
    model_on = 1'b1;

    // single op
    chk("single_tag", bus.launch_tag_o, 0);
    launch(5);
    chk("single_lock5", bus.locks_o[5], 1);
    chk("single_tag_next", bus.launch_tag_o, 1);
    complete(0, 64'hDEAD_BEEF);
`ifndef RV64G_WB_BYPASS_EN
    chk("single_wb_valid", bus.wb_valid_o, 1);
    chk("single_wb_rd", bus.wb_rd_o, 5);
    chk("single_wb_data", bus.wb_data_o, 64'hDEAD_BEEF);
    tick();
`endif
    chk("single_locks_clear", bus.locks_o, 0);
    chk("single_wb_idle", bus.wb_valid_o, 0);

    // out-of-order completion, in-order writeback
    do_flush();
    launch(1); launch(2); launch(3);
    complete(2, 64'hA2);
    complete(1, 64'hA1);
    chk("ooo_hold", bus.wb_valid_o, 0);
    complete(0, 64'hA0);
`ifndef RV64G_WB_BYPASS_EN
    chk("ooo_first_valid", bus.wb_valid_o, 1);
    chk("ooo_first_rd", bus.wb_rd_o, 1);
`endif
    tick(); tick(); tick();
    chk("ooo_drained", bus.wb_valid_o, 0);
    chk("ooo_locks", bus.locks_o, 0);

    // full and wrap
    do_flush();
    for (int i = 0; i < 7; i++) launch(10 + i);
    chk("full_ready", bus.launch_ready_o, 0);
    chk("full_tag_wrap", bus.launch_tag_o, 0);
    chk("full_locks", bus.locks_o, 64'h1FC00);
    bus.wb_ready_i = 1'b0;
    complete(0, 64'h111);
    chk("full_wb_valid", bus.wb_valid_o, 1);
    bus.wb_ready_i     = 1'b1;
    bus.launch_valid_i = 1'b1;
    bus.launch_rd_i    = 6'd20;
    tick();
    chk("full_refused_ready", bus.launch_ready_o, 1);
    chk("full_refused_lock20", bus.locks_o[20], 0);
    chk("full_retired_lock10", bus.locks_o[10], 0);
    chk("wrap_tag", bus.launch_tag_o, 0);
    launch(20);
    chk("wrap_lock20", bus.locks_o[20], 1);
    chk("wrap_ready", bus.launch_ready_o, 0);

    // completion errors
    do_flush();
    bus.wb_ready_i = 1'b0;
    launch(6); launch(7);
    complete(4, 64'h44);
    chk("err_free_tag", bus.cmpl_err_o, 1);
    tick();
    chk("err_pulse_end", bus.cmpl_err_o, 0);
    complete(1, 64'hA1);
    chk("err_none", bus.cmpl_err_o, 0);
    complete(1, 64'hB2);
    chk("err_done_tag", bus.cmpl_err_o, 1);
    complete(7, 64'h77);
    chk("err_range_tag", bus.cmpl_err_o, 1);
    complete(0, 64'hC0);
    chk("err_wb_rd", bus.wb_rd_o, 6);
    chk("err_wb_data", bus.wb_data_o, 64'hC0);
    bus.wb_ready_i = 1'b1;
    tick();
    chk("err_kept_data", bus.wb_data_o, 64'hA1);
    tick();
    chk("err_drained", bus.wb_valid_o, 0);

    // same-rd locks and rd 0
    do_flush();
    bus.wb_ready_i = 1'b0;
    launch(9); launch(9); launch(0);
    chk("samerd_locks", bus.locks_o, 64'h200);
    complete(0, 64'h90);
    bus.wb_ready_i = 1'b1;
    tick();
    chk("samerd_still", bus.locks_o[9], 1);
    complete(1, 64'h91);
    tick();
    chk("samerd_clear", bus.locks_o, 0);
    bus.wb_ready_i = 1'b0;
    complete(2, 64'h5);
    chk("rd0_wb_valid", bus.wb_valid_o, 1);
    chk("rd0_wb_rd", bus.wb_rd_o, 0);
    bus.wb_ready_i = 1'b1;
    tick();
    chk("rd0_retired", bus.wb_valid_o, 0);

    // backpressure then flush
    do_flush();
    bus.wb_ready_i = 1'b0;
    launch(3); launch(4); launch(5);
    complete(0, 64'hF00D);
    complete(1, 64'hF11D);
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", bus.wb_valid_o, 1);
      chk("bp_rd", bus.wb_rd_o, 3);
      chk("bp_data", bus.wb_data_o, 64'hF00D);
      tick();
    end
    flush              = 1'b1;
    bus.wb_ready_i     = 1'b1;
    bus.launch_valid_i = 1'b1;
    bus.launch_rd_i    = 6'd40;
    bus.cmpl_valid_i   = 1'b1;
    bus.cmpl_tag_i     = 3'd2;
    bus.cmpl_data_i    = 64'hBAD;
    tick();
    chk("flush_locks", bus.locks_o, 0);
    chk("flush_wb_valid", bus.wb_valid_o, 0);
    chk("flush_ready", bus.launch_ready_o, 1);
    chk("flush_tag", bus.launch_tag_o, 0);
    chk("flush_err", bus.cmpl_err_o, 0);
    tick();
    chk("flush_err_after", bus.cmpl_err_o, 0);

`ifdef RV64G_WB_BYPASS_EN
    launch(7);
    bus.cmpl_valid_i = 1'b1;
    bus.cmpl_tag_i   = 3'd0;
    bus.cmpl_data_i  = 64'hB1;
    #1;
    chk("byp_wb_valid", bus.wb_valid_o, 1);
    chk("byp_wb_data", bus.wb_data_o, 64'hB1);
    tick();
    chk("byp_locks", bus.locks_o, 0);
    chk("byp_idle", bus.wb_valid_o, 0);
`endif

    repeat (2) tick();
    model_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
